// File: rtl/cavlc_coef_rebuild_pkg.sv
// Shared CAVLC definitions: FSM state encoding, coefficient width default,
// block-size constants and buffer-index helper.
package cavlc_coef_rebuild_pkg;

  localparam int unsigned COEF_W_DEFAULT = 16;
  localparam int unsigned NCOEF          = 16;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned SUM_W          = CNT_W + 1;
  localparam int unsigned RUN_W          = 4;
  localparam int unsigned BEAT_W         = 3;

  localparam logic [CNT_W-1:0] MAXC_4x4 = CNT_W'(16);
  localparam logic [CNT_W-1:0] MAXC_AC  = CNT_W'(15);
  localparam logic [CNT_W-1:0] MAXC_CDC = CNT_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // Positions past the end of a 16-entry block pin to its top index.
  function automatic logic [IDX_W-1:0] pos_to_idx(input logic [CNT_W-1:0] pos);
    return (pos >= MAXC_4x4) ? IDX_W'(MAXC_AC) : pos[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/cavlc_coef_buf.sv
// 16-entry coefficient buffer for one CAVLC block.
// Ports: clk, rst (sync, active-high clear), clr (sync clear), we/wr_idx/wr_data
// (single indexed write), rd_beat (beat index) -> rd_lo_c = coef[2k],
// rd_hi_c = coef[2k+1] (combinational read of the stored entries).
module cavlc_coef_buf
  import cavlc_coef_rebuild_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic [COEF_W-1:0] rd_lo_c,
  output logic [COEF_W-1:0] rd_hi_c
);

  logic [COEF_W-1:0] mem_q [NCOEF];
  logic [COEF_W-1:0] mem_d [NCOEF];

  // Clear wins over write; clear only happens on header acceptance.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < int'(NCOEF); i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCOEF); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_lo_c = mem_q[{rd_beat, 1'b0}];
  assign rd_hi_c = mem_q[{rd_beat, 1'b1}];

endmodule

// File: rtl/cavlc_coef_rebuild.sv
// CAVLC decode-side coefficient reconstruction. Takes a TotalCoeff/TotalZeros
// header and the reverse-ordered (level, run_before) stream of one 4x4, AC or
// chroma-DC block, places each level at its scan position and streams the
// block out as eight beats of two coefficients.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_valid/start_ready       header handshake (ready only in IDLE)
//   total_coeff, total_zeros      block header
//   max_coeff, blk_start          block size (16/15/4), first index (1 for AC)
//   in_valid/in_ready, in_level, in_run    level/run stream, highest freq first
//   out_valid/out_ready, out_coef, out_beat, out_last  {coef[2k+1], coef[2k]}
//   out_nnz                       latched total_coeff
//   err                           sticky inconsistency flag, cleared on start
// Optional: define CAVLC_COEF_REBUILD_ERRCHK_EN to enable header/run checking
// and clamping; otherwise err is tied low.
module cavlc_coef_rebuild
  import cavlc_coef_rebuild_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [CNT_W-1:0]    total_coeff,
  input  logic [RUN_W-1:0]    total_zeros,
  input  logic [CNT_W-1:0]    max_coeff,
  input  logic                blk_start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COEF_W-1:0]   in_level,
  input  logic [RUN_W-1:0]    in_run,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*COEF_W-1:0] out_coef,
  output logic [BEAT_W-1:0]   out_beat,
  output logic                out_last,
  output logic [CNT_W-1:0]    out_nnz,
  output logic                err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [CNT_W-1:0]    nnz_q, nnz_d;
  logic                start_ready_q, start_ready_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   out_beat_q, out_beat_d;
  logic                out_last_q, out_last_d;
  logic [2*COEF_W-1:0] out_coef_q, out_coef_d;

  logic [CNT_W-1:0]    hdr_tc_c;
  logic [RUN_W-1:0]    hdr_tz_c;
  logic [RUN_W-1:0]    run_eff_c;
  logic                load_c, clr_c;
  logic [IDX_W-1:0]    widx_c;
  logic [BEAT_W-1:0]   rd_beat_c;
  logic [COEF_W-1:0]   rd_lo_c, rd_hi_c;
  logic [COEF_W-1:0]   pair_lo_c, pair_hi_c;

`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
  logic [RUN_W-1:0]    zl_q, zl_d;
  logic                err_q, err_d;
  logic                hdr_err_c, run_err_c;
`endif

  // Header sanitising: clamp TotalCoeff, then TotalZeros against block size.
  always_comb begin
    hdr_tc_c = total_coeff;
    hdr_tz_c = total_zeros;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
    hdr_err_c = 1'b0;
    if (total_coeff > max_coeff) begin
      hdr_tc_c  = max_coeff;
      hdr_err_c = 1'b1;
    end
    if ((SUM_W'(hdr_tc_c) + SUM_W'(total_zeros)) > SUM_W'(max_coeff)) begin
      hdr_tz_c  = RUN_W'(max_coeff - hdr_tc_c);
      hdr_err_c = 1'b1;
    end
`endif
  end

  // A run can never consume more zeros than remain below the current level.
  always_comb begin
    run_eff_c = in_run;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
    run_err_c = 1'b0;
    if (in_run > zl_q) begin
      run_eff_c = zl_q;
      run_err_c = 1'b1;
    end
`endif
  end

  assign load_c    = (state_q == ST_LOAD) && in_valid;
  assign clr_c     = (state_q == ST_IDLE) && start_valid;
  assign widx_c    = pos_to_idx(pos_q);
  assign rd_beat_c = (state_q == ST_SCAN) ? out_beat_q + BEAT_W'(1) : '0;

  cavlc_coef_buf #(
    .COEF_W (COEF_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_c),
    .we      (load_c),
    .wr_idx  (widx_c),
    .wr_data (in_level),
    .rd_beat (rd_beat_c),
    .rd_lo_c (rd_lo_c),
    .rd_hi_c (rd_hi_c)
  );

  // Next beat's pair; forwards the final level so beat 0 registers without a bubble.
  always_comb begin
    pair_lo_c = rd_lo_c;
    pair_hi_c = rd_hi_c;
    if (load_c && (widx_c == {rd_beat_c, 1'b0})) pair_lo_c = in_level;
    if (load_c && (widx_c == {rd_beat_c, 1'b1})) pair_hi_c = in_level;
    if ((max_q == MAXC_CDC) && (rd_beat_c >= BEAT_W'(2))) begin
      pair_lo_c = '0;
      pair_hi_c = '0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    rem_d       = rem_q;
    max_d       = max_q;
    nnz_d       = nnz_q;
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    out_last_d  = out_last_q;
    out_coef_d  = out_coef_q;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
    zl_d        = zl_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          pos_d = CNT_W'(blk_start) + hdr_tc_c + CNT_W'(hdr_tz_c) - CNT_W'(1);
          rem_d = hdr_tc_c;
          max_d = max_coeff;
          nnz_d = hdr_tc_c;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
          zl_d  = hdr_tz_c;
          err_d = hdr_err_c;
`endif
          if (hdr_tc_c == '0) begin
            state_d     = ST_SCAN;
            out_valid_d = 1'b1;
            out_beat_d  = '0;
            out_last_d  = 1'b0;
            out_coef_d  = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q > CNT_W'(1)) begin
            pos_d = pos_q - CNT_W'(1) - CNT_W'(run_eff_c);
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
            zl_d  = zl_q - run_eff_c;
            err_d = err_q | run_err_c;
`endif
          end else begin
            // Last level: its run is implied by the zeros still left below it.
            state_d     = ST_SCAN;
            out_valid_d = 1'b1;
            out_beat_d  = '0;
            out_last_d  = 1'b0;
            out_coef_d  = {pair_hi_c, pair_lo_c};
          end
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_beat_d = rd_beat_c;
            out_last_d = (rd_beat_c == BEAT_W'(7));
            out_coef_d = {pair_hi_c, pair_lo_c};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_ready_d = (state_d == ST_IDLE);
    in_ready_d    = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      rem_q         <= '0;
      max_q         <= '0;
      nnz_q         <= '0;
      start_ready_q <= 1'b1;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_beat_q    <= '0;
      out_last_q    <= 1'b0;
      out_coef_q    <= '0;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
      zl_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      rem_q         <= rem_d;
      max_q         <= max_d;
      nnz_q         <= nnz_d;
      start_ready_q <= start_ready_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_beat_q    <= out_beat_d;
      out_last_q    <= out_last_d;
      out_coef_q    <= out_coef_d;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
      zl_q          <= zl_d;
      err_q         <= err_d;
`endif
    end
  end

  assign start_ready = start_ready_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_beat    = out_beat_q;
  assign out_last    = out_last_q;
  assign out_coef    = out_coef_q;
  assign out_nnz     = nnz_q;
`ifdef CAVLC_COEF_REBUILD_ERRCHK_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: doc/cavlc_coef_rebuild.md
# cavlc_coef_rebuild

CAVLC decode-side coefficient reconstruction. Consumes the TotalCoeff/TotalZeros header and the reverse-ordered (level, run_before) stream of one 4x4, AC, or chroma-DC block. Places each level at its zig-zag position and streams the rebuilt block out two coefficients per cycle over eight beats. This matches the 2-coefficient/8-cycle scan cadence of the encoder statistics path, so both ends share one block format.

## Interface
- COEF_W, 16, signed level / output coefficient width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_valid  in  1  block header valid
- start_ready  out  1  high only in IDLE
- total_coeff  in  5  non-zero count, 0..16
- total_zeros  in  4  zeros below the last non-zero coefficient
- max_coeff  in  5  16 for 4x4, 15 for AC, 4 for chroma DC
- blk_start  in  1  1 = first stored index is 1 (AC blocks)
- in_valid / in_ready  in/out  1  level/run handshake
- in_level  in  COEF_W  signed level, highest frequency first
- in_run  in  4  run_before following this level
- out_valid / out_ready  out/in  1  coefficient-pair handshake
- out_coef  out  2*COEF_W  {coef[2k+1], coef[2k]}
- out_beat  out  3  beat index k
- out_last  out  1  beat 7
- out_nnz  out  5  latched total_coeff, for nC prediction
- err  out  1  sticky bitstream-inconsistency flag, cleared on next start

## Operation
- States: IDLE, LOAD, SCAN. Reset and every start acceptance clear the 16-entry buffer.
- IDLE, start_valid:
  - Latch the header.
  - pos = blk_start + total_coeff + total_zeros - 1 (5-bit). zeros_left = total_zeros. remaining = total_coeff.
  - If total_coeff == 0, go to SCAN; else go to LOAD.
- LOAD, in_ready = 1. Each accepted pair:
  - coef[pos] = in_level; remaining -= 1.
  - If remaining > 1 before the decrement: pos -= 1 + in_run, zeros_left -= in_run.
  - For the last level, in_run is ignored; the leftover zeros_left lie below it.
  - When remaining reaches 0, go to SCAN.
- SCAN: beat k presents coef[2k], coef[2k+1] for k = 0..7. The last beat accepted returns to IDLE. For chroma DC, indices 4..15 are zero.
- Arithmetic: all position math is unsigned 5-bit; the buffer index never exceeds 15 after clamping.

## Timing
- Reset: state IDLE; start_ready = 1; in_ready, out_valid, out_last, err = 0; out_coef, out_beat, out_nnz = 0; buffer zero.
- Start accepted at cycle T. First pair can be accepted at T+1, one pair per cycle with no bubbles.
- First out_valid is one cycle after the last pair is accepted, or at T+1 when total_coeff == 0.
- out_* hold stable while out_valid && !out_ready.
- A new header is accepted no earlier than the cycle after the out_last handshake.
- in_valid in IDLE/SCAN and start_valid outside IDLE are ignored, not queued.
- Reset mid-block: the block is abandoned; the next start is accepted the cycle after rst deasserts.

## Configuration
- CAVLC_COEF_REBUILD_ERRCHK_EN defined:
  - total_coeff > max_coeff: err = 1, clamp total_coeff to max_coeff.
  - total_coeff + total_zeros > max_coeff: err = 1, clamp total_zeros to max_coeff - total_coeff.
  - in_run > zeros_left: err = 1, use zeros_left.
- Not defined: no checks or clamps, err tied to 0, behaviour on illegal input is undefined.

## Structure
- Shared CAVLC package:
  - state encoding IDLE/LOAD/SCAN
  - COEF_W default
  - block-size constants MAXC_4x4 = 16, MAXC_AC = 15, MAXC_CDC = 4
- One sub-module, cavlc_coef_buf: 16 x COEF_W register array with synchronous clear, single indexed write, and 2-entry read by beat index.

## Test plan
- Block 0,3,-1,0,0,-1,1,0,1,0... : TC = 5, TZ = 4, max 16, blk_start 0; pairs (1,1),(1,0),(-1,2),(-1,0),(3,x) -> beats (0,3),(-1,0),(0,-1),(1,0),(1,0), then 3 zero beats; nnz = 5; err = 0.
- TC = 0 -> eight zero beats starting at T+1, no in_ready pulse.
- AC block, blk_start = 1, max 15, TC = 1, TZ = 0, level 7 -> coef[1] = 7, all others 0.
- out_ready low 3 cycles on beat 2 -> beat 2 data held; total 8 beats, out_last only on beat 7.
- ERRCHK_EN defined, TC = 2, TZ = 1, first run 3 -> err = 1; run clamped to 1; levels at indices 2 and 0; err cleared on the next start.
- rst asserted during LOAD after 2 of 5 pairs -> IDLE next cycle; the following block's output contains no stale levels.
